// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, write-back opcodes and the FIFO entry type.
package cpu_pkg;
    localparam int N_DEFAULT = 16;
    localparam int AW_DEFAULT = 3;
    localparam logic [3:0] OP_0 = 4'h0;
    localparam logic [3:0] OP_1 = 4'h1;
    localparam logic [3:0] OP_2 = 4'h2;
    localparam logic [3:0] OP_3 = 4'h3;
    localparam logic [3:0] OP_4 = 4'h4;

    function automatic logic is_wb_op(input logic [3:0] op);
        return op <= OP_4;
    endfunction

    typedef struct packed {
        logic [AW_DEFAULT-1:0] rd;
        logic [N_DEFAULT-1:0]  data;
    } wb_entry_t;
endpackage

// File: rtl/rd_writeback_fifo.sv
// wb_fifo: small write-back FIFO exposing head (older) and tail (younger) entries for bypass.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    din,
    output wb_entry_t                    old_e,
    output wb_entry_t                    young_e,
    output logic                         old_v,
    output logic                         young_v,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign old_e   = mem[rd_ptr];
    assign young_e = mem[rd_ptr + PW'(1)];
    assign old_v   = count != '0;
    assign young_v = count == CW'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/rd_writeback.sv
// rd_writeback: buffers ALU results, commits one per cycle into the register file,
// and serves two read ports that bypass from still-pending entries.
module rd_writeback
    import cpu_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int REGS  = 8,
    parameter int AW    = $clog2(REGS),
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [3:0]    wb_op_code,
    input  logic [AW-1:0] wb_rd,
    input  logic [N-1:0]  wb_data,
    input  logic          wb_hold,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic [N-1:0]  rs1_out,
    output logic [N-1:0]  rs2_out,
    output logic [1:0]    pending,
    output logic [15:0]   commit_cnt
);
    wb_entry_t din, old_e, young_e;
    logic old_v, young_v, push, pop;
    logic [N-1:0] regs [REGS];

    assign din      = {wb_rd, wb_data};
    assign wb_ready = pending != 2'(DEPTH);
    assign push     = wb_valid && wb_ready && is_wb_op(wb_op_code);
    assign pop      = old_v && !wb_hold;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .old_e   (old_e),
        .young_e (young_e),
        .old_v   (old_v),
        .young_v (young_v),
        .count   (pending)
    );

    // Younger pending write wins over older, which wins over the register file.
    always_comb begin
        rs1_out = (young_v && young_e.rd == rs1_addr) ? young_e.data :
                  (old_v && old_e.rd == rs1_addr)     ? old_e.data   : regs[rs1_addr];
        rs2_out = (young_v && young_e.rd == rs2_addr) ? young_e.data :
                  (old_v && old_e.rd == rs2_addr)     ? old_e.data   : regs[rs2_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++)
                regs[i] <= '0;
            commit_cnt <= '0;
        end else if (pop) begin
            regs[old_e.rd] <= old_e.data;
            commit_cnt     <= commit_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_rd_writeback.sv
// tb_rd_writeback: directed vector table, then random traffic against a queue-based model,
// then a long commit stream to exercise commit_cnt wrap.
module tb_rd_writeback;
    logic clk = 1'b0;
    logic rst, wb_valid, wb_ready, wb_hold;
    logic [3:0] wb_op_code;
    logic [2:0] wb_rd, rs1_addr, rs2_addr;
    logic [15:0] wb_data, rs1_out, rs2_out, commit_cnt;
    logic [1:0] pending;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rd_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_op_code (wb_op_code),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_hold    (wb_hold),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_out    (rs1_out),
        .rs2_out    (rs2_out),
        .pending    (pending),
        .commit_cnt (commit_cnt)
    );

    typedef struct {
        logic rst, valid;
        logic [3:0] op;
        logic [2:0] rd;
        logic [15:0] data;
        logic hold;
        logic [2:0] a1, a2;
        logic chk, ready;
        logic [1:0] pend;
        logic [15:0] r1, r2, cnt;
    } vec_t;

    typedef struct {
        logic [2:0] rd;
        logic [15:0] data;
    } ent_t;

    vec_t tbl [22];
    ent_t q [$];
    logic [15:0] m_regs [8];
    logic [15:0] m_cnt;

    function automatic vec_t mk(int r, int v, int op, int rd, int d, int h, int a1, int a2,
                                int c, int rdy, int p, int r1, int r2, int cnt);
        vec_t x;
        x.rst = r[0]; x.valid = v[0]; x.op = op[3:0]; x.rd = rd[2:0]; x.data = d[15:0];
        x.hold = h[0]; x.a1 = a1[2:0]; x.a2 = a2[2:0]; x.chk = c[0]; x.ready = rdy[0];
        x.pend = p[1:0]; x.r1 = r1[15:0]; x.r2 = r2[15:0]; x.cnt = cnt[15:0];
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == a) return q[i].data;
        return m_regs[a];
    endfunction

    // Compare DUT against the model, then advance the model across the next edge.
    task automatic step();
        bit acc;
        #1;
        check("rand ready", {31'd0, wb_ready}, {31'd0, q.size() < 2});
        check("rand pending", {30'd0, pending}, q.size());
        check("rand rs1", {16'd0, rs1_out}, {16'd0, m_read(rs1_addr)});
        check("rand rs2", {16'd0, rs2_out}, {16'd0, m_read(rs2_addr)});
        check("rand commit_cnt", {16'd0, commit_cnt}, {16'd0, m_cnt});
        acc = wb_valid && q.size() < 2;
        if (rst) begin
            q.delete();
            foreach (m_regs[i]) m_regs[i] = 16'h0;
            m_cnt = 16'h0;
        end else begin
            if (q.size() > 0 && !wb_hold) begin
                m_regs[q[0].rd] = q[0].data;
                void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (acc && wb_op_code < 4'd5)
                q.push_back('{rd: wb_rd, data: wb_data});
        end
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,0,0,0,0,        0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0,1,        1,1,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0,2,3,        1,1,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0,4,5,        1,1,0,0,0,0);
        tbl[4]  = mk(0,0,0,0,0,0,6,7,        1,1,0,0,0,0);
        tbl[5]  = mk(0,1,0,3,'hBEEF,0,0,3,   1,1,0,0,0,0);
        tbl[6]  = mk(0,0,0,0,0,0,0,3,        1,1,1,0,'hBEEF,0);
        tbl[7]  = mk(0,0,0,0,0,0,3,3,        1,1,0,'hBEEF,'hBEEF,1);
        tbl[8]  = mk(0,1,7,5,'h1234,0,5,3,   1,1,0,0,'hBEEF,1);
        tbl[9]  = mk(0,0,0,0,0,0,5,3,        1,1,0,0,'hBEEF,1);
        tbl[10] = mk(0,1,1,2,1,1,2,3,        1,1,0,0,'hBEEF,1);
        tbl[11] = mk(0,1,2,2,2,1,2,3,        1,1,1,1,'hBEEF,1);
        tbl[12] = mk(0,1,0,6,'hDEAD,1,2,6,   1,0,2,2,0,1);
        tbl[13] = mk(0,1,0,6,'hDEAD,0,2,6,   1,0,2,2,0,1);
        tbl[14] = mk(0,1,0,6,'hDEAD,0,2,6,   1,1,1,2,0,2);
        tbl[15] = mk(0,0,0,0,0,0,2,6,        1,1,1,2,'hDEAD,3);
        tbl[16] = mk(0,0,0,0,0,0,6,2,        1,1,0,'hDEAD,2,4);
        tbl[17] = mk(0,1,0,1,'h1111,1,1,4,   1,1,0,0,0,4);
        tbl[18] = mk(0,1,3,4,'h4444,1,1,4,   1,1,1,'h1111,0,4);
        tbl[19] = mk(1,0,0,0,0,1,1,4,        1,0,2,'h1111,'h4444,4);
        tbl[20] = mk(0,0,0,0,0,0,1,4,        1,1,0,0,0,0);
        tbl[21] = mk(0,0,0,0,0,0,3,2,        1,1,0,0,0,0);

        rst = 1'b1; wb_valid = 1'b0; wb_hold = 1'b0; wb_op_code = 4'h0;
        wb_rd = 3'd0; wb_data = 16'h0; rs1_addr = 3'd0; rs2_addr = 3'd0;
        @(negedge clk);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; wb_valid = tbl[i].valid; wb_op_code = tbl[i].op;
            wb_rd = tbl[i].rd; wb_data = tbl[i].data; wb_hold = tbl[i].hold;
            rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
            #1;
            if (tbl[i].chk) begin
                check($sformatf("row%0d ready", i), {31'd0, wb_ready}, {31'd0, tbl[i].ready});
                check($sformatf("row%0d pending", i), {30'd0, pending}, {30'd0, tbl[i].pend});
                check($sformatf("row%0d rs1", i), {16'd0, rs1_out}, {16'd0, tbl[i].r1});
                check($sformatf("row%0d rs2", i), {16'd0, rs2_out}, {16'd0, tbl[i].r2});
                check($sformatf("row%0d commit_cnt", i), {16'd0, commit_cnt}, {16'd0, tbl[i].cnt});
            end
            @(negedge clk);
        end

        rst = 1'b1; wb_valid = 1'b0; wb_hold = 1'b0;
        step();
        for (int n = 0; n < 600; n++) begin
            rst        = $urandom_range(0, 99) < 2;
            wb_valid   = $urandom_range(0, 99) < 70;
            wb_hold    = $urandom_range(0, 99) < 30;
            wb_op_code = 4'($urandom_range(0, 15));
            wb_rd      = 3'($urandom_range(0, 7));
            wb_data    = 16'($urandom);
            rs1_addr   = 3'($urandom_range(0, 7));
            rs2_addr   = 3'($urandom_range(0, 7));
            step();
        end

        rst = 1'b0; wb_hold = 1'b0; wb_valid = 1'b1;
        for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) begin
            wb_op_code = 4'($urandom_range(0, 4));
            wb_rd      = 3'($urandom_range(0, 7));
            wb_data    = 16'($urandom);
            rs1_addr   = 3'($urandom_range(0, 7));
            rs2_addr   = 3'($urandom_range(0, 7));
            step();
        end
        check("stream reached FFFF", {16'd0, commit_cnt}, 32'h0000FFFF);
        wb_valid = 1'b0;
        step();
        check("commit_cnt wrap", {16'd0, commit_cnt}, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
